// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM Avalon-MM two-master arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_t;

    // Tag recorded per outstanding read: index of the master that issued it.
    typedef logic tag_t;

    localparam int DEF_ADDR_W   = 25;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_PEND = 8;
    localparam int DEF_HOLD_MAX = 16;

endpackage

// File: rtl/sdram_avmm_arbiter_if.sv
// Avalon-MM pipelined-read bus bundle; master drives commands, slave returns status/data.
interface sdram_avmm_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// Read-tag FIFO: one entry per outstanding read, popped by each read return.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_PEND,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  tag_t din,
    input  logic pop,
    output tag_t dout,
    output logic full,
    output logic empty
);
    tag_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sdram_avmm_arbiter.sv
// Round-robin arbiter with bounded hold sharing one SDRAM controller slave between two masters;
// read returns are steered back to their issuer through an in-order tag FIFO.
module sdram_avmm_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_PEND = DEF_MAX_PEND,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    sdram_avmm_arbiter_if.slave  m0,
    sdram_avmm_arbiter_if.slave  m1,
    sdram_avmm_arbiter_if.master s,
    output logic                 rdv_orphan
);
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    arb_state_t    state;
    logic          last;
    logic [HW-1:0] hold_cnt;

    logic req0, req1, gnt0, gnt1, own_req, oth_req;
    logic g_read, g_write, accept, hold_sat, full, empty;
    tag_t head;

    assign req0    = m0.read | m0.write;
    assign req1    = m1.read | m1.write;
    assign gnt0    = state == G0;
    assign gnt1    = state == G1;
    assign own_req = gnt0 ? req0 : req1;
    assign oth_req = gnt0 ? req1 : req0;

    assign g_read  = (gnt0 & m0.read)  | (gnt1 & m1.read);
    assign g_write = (gnt0 & m0.write) | (gnt1 & m1.write);

    assign s.address    = gnt1 ? m1.address    : m0.address;
    assign s.writedata  = gnt1 ? m1.writedata  : m0.writedata;
    assign s.byteenable = gnt1 ? m1.byteenable : m0.byteenable;
    assign s.read       = g_read & ~full;
    assign s.write      = g_write;

    assign accept   = (s.read | s.write) & ~s.waitrequest;
    assign hold_sat = hold_cnt == HW'(HOLD_MAX - 1);

    // A read blocked by a full tag FIFO stalls its master like controller backpressure.
    assign m0.waitrequest = gnt0 ? (s.waitrequest | (m0.read & full)) : 1'b1;
    assign m1.waitrequest = gnt1 ? (s.waitrequest | (m1.read & full)) : 1'b1;

    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
    assign m0.readdatavalid = s.readdatavalid & ~empty & (head == 1'b0);
    assign m1.readdatavalid = s.readdatavalid & ~empty & (head == 1'b1);

    sdram_arb_tag_fifo #(.DEPTH(MAX_PEND)) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (s.read & ~s.waitrequest),
        .din   (tag_t'(gnt1)),
        .pop   (s.readdatavalid),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            last       <= 1'b1;
            hold_cnt   <= '0;
            rdv_orphan <= 1'b0;
        end else begin
            if (s.readdatavalid && empty)
                rdv_orphan <= 1'b1;
            case (state)
                IDLE: begin
                    // On a tie the master not served last wins.
                    if (req0 && (!req1 || last)) begin
                        state <= G0;
                        last  <= 1'b0;
                    end else if (req1) begin
                        state <= G1;
                        last  <= 1'b1;
                    end
                end
                G0, G1: begin
                    if (!own_req || (accept && hold_sat && oth_req)) begin
                        hold_cnt <= '0;
                        if (oth_req) begin
                            state <= gnt0 ? G1 : G0;
                            last  <= gnt0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept && !hold_sat) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sdram_avmm_arbiter.md
# sdram_avmm_arbiter

Two-requester Avalon-MM arbiter that shares the single Avalon-MM slave of the SDRAM controller inside the `avalon` system between two masters: m0, e.g. a frame/stream engine, and m1, e.g. CPU/bridge. It sits in the `clk_clk` domain directly in front of the controller slave port. It grants round-robin with a bounded hold count. It tracks outstanding pipelined reads in a tag FIFO so that each `readdatavalid` returns to the master that issued the read.

## Interface
Parameters:
- `ADDR_W`, 25: word address width (13 row + 10 col + 2 bank).
- `DATA_W`, 16: data width; byteenable width is DATA_W/8.
- `MAX_PEND`, 8: maximum outstanding reads, equal to the tag FIFO depth; power of two, at least 2.
- `HOLD_MAX`, 16: maximum accepted commands per grant while the other master is waiting.

Ports:
- `clk_clk`  in  1  system clock; all logic is on the rising edge.
- `reset_reset_n`  in  1  synchronous, active-low reset.
- `m{0,1}_address`  in  ADDR_W  requester word address.
- `m{0,1}_read`, `m{0,1}_write`  in  1  command strobes; mutually exclusive per master.
- `m{0,1}_writedata`  in  DATA_W  write data.
- `m{0,1}_byteenable`  in  DATA_W/8  byte lanes.
- `m{0,1}_waitrequest`  out  1  command not accepted this cycle.
- `m{0,1}_readdata`  out  DATA_W  read return data.
- `m{0,1}_readdatavalid`  out  1  read return strobe.
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`  out  controller slave command.
- `s_waitrequest`  in  1  controller backpressure.
- `s_readdata`  in  DATA_W, `s_readdatavalid`  in  1  controller read return.
- `rdv_orphan`  out  1  sticky error flag: `s_readdatavalid` arrived with the tag FIFO empty.

## Operation
- The grant state machine has three states:
  - IDLE: no master is granted.
  - G0: m0 is granted.
  - G1: m1 is granted.
- Transitions from IDLE:
  - Only m0 requesting → G0.
  - Only m1 requesting → G1.
  - Both requesting → the master not served last, tracked by a `last` register that resets to 1, so m0 wins first.
- Transitions from Gx: move to G(other) or IDLE only in a cycle where the Gx master is not requesting, or its command is accepted (`s_waitrequest`=0) and `hold_cnt`=HOLD_MAX-1 while the other master is requesting.
  - The grant never changes while a granted command is stalled.
  - With no other requester, the grant is held indefinitely and `hold_cnt` saturates.
- `hold_cnt` clears on every grant change and increments on each accepted command of the granted master.
- The `s_*` command signals are combinational from the granted master. With no grant, `s_read`=`s_write`=0.
- The granted master's `waitrequest` equals `s_waitrequest`, OR'd with `tagfifo_full` when that master is issuing a read. When the FIFO is full, the read is not forwarded: `s_read` is forced to 0.
- Non-granted masters see `waitrequest`=1.
- An accepted read pushes the tag (the granted master index) into the FIFO.
- Each `s_readdatavalid` pops the FIFO head. The return is routed to `m[head]_readdatavalid`. `s_readdata` fans out to both `readdata` ports.
- An orphan `s_readdatavalid` (FIFO empty) is dropped and sets `rdv_orphan`.
- Writes are never tracked.

## Timing
- Request-to-grant latency: 1 cycle from IDLE. The first command is presented on `s_*` in the cycle after the request is first seen.
- Back-to-back commands from the granted master proceed at 1 per cycle with no bubbles.
- Grant switch with the other master waiting: 1 cycle. The new master's command appears in the cycle after the last accepted command of the old master.
- Read return routing is combinational, with 0 added latency. Return order equals issue order across both masters.
- FIFO push and pop may occur in the same cycle; occupancy is unchanged. Push is refused whenever occupancy = MAX_PEND, even if a pop happens in that cycle.
- Reset, including mid-transfer, gives:
  - state=IDLE, `last`=1, `hold_cnt`=0;
  - FIFO emptied;
  - `rdv_orphan`=0;
  - all `m*_readdatavalid`=0;
  - `m*_waitrequest`=1, since no master is granted.
- Returns for reads issued before reset arrive as orphans: they are dropped and flagged.

## Structure
- Shared package `sdram_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE/G0/G1);
  - the tag type (1 bit);
  - default parameter constants.
- Sub-module `sdram_arb_tag_fifo`: a synchronous FIFO of MAX_PEND×1-bit entries with a log2(MAX_PEND)+1 occupancy count, `full`/`empty` outputs, and a same-cycle push/pop rule.
- The top level contains the grant FSM, the hold counter, and the command/return muxing.

## Test plan
- m0 only, 4 writes at addr 0x000010..13 with `s_waitrequest`=0 → grant in cycle 1 and 4 consecutive `s_write` cycles; m1 `waitrequest`=1 throughout.
- Both masters continuously reading with HOLD_MAX=4 → grant sequence m0×4, m1×4, m0×4; each `readdatavalid` goes to the issuer in issue order.
- `s_waitrequest` held high for 5 cycles mid-command while m1 requests → grant stays on m0 until the command is accepted, and the `s_*` command stays stable.
- Controller withholds `readdatavalid`, m0 issues 9 reads with MAX_PEND=8 → 8 reads are forwarded. On the 9th, `s_read`=0 and `m0_waitrequest`=1 until the first return, then the 9th read is accepted in that same cycle's successor.
- Reset asserted with 3 reads outstanding, then 3 `s_readdatavalid` pulses → no `m*_readdatavalid` pulse; `rdv_orphan` goes to 1 and stays 1.
- Simultaneous push and pop at occupancy 7 → occupancy stays 7; at occupancy 8 the push is refused.
